wb_stage: RTL and testbench

Writeback stage of the 8-bit CSE141L datapath, sitting between execute/data-memory and the register file. It registers each completed instruction's result and drives the register file's write port (WriteEn, Immediate, ImmediateValue, Waddr, DataIn). It also forwards the in-flight write to the decode-stage operand reads and raises a one-cycle stall on load-use hazards.

---
 rtl/wb_pkg.sv | 33 +++
 rtl/wb_fwd_mux.sv | 25 ++
 rtl/wb_stage.sv | 129 ++++++++++++
 tb/tb_wb_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   W, D      : data and register-address widths
//   ACC_ADDR  : accumulator address, the forced target of immediate writes
//   wb_slot_t : contents of the capture register S1
//   wb_state_t: writeback FSM states
package wb_pkg;

  localparam int W = 8;
  localparam int D = 4;

  localparam logic [D-1:0] ACC_ADDR = '0;

  typedef struct packed {
    logic         valid;
    logic         we;
    logic         imm;
    logic [W-1:0] immval;
    logic [D-1:0] waddr;
    logic [W-1:0] aluresult;
    logic         isload;
  } wb_slot_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

  // Immediate writes always land in the accumulator, whatever waddr says.
  function automatic logic [D-1:0] eff_addr(input logic imm, input logic [D-1:0] waddr);
    return imm ? ACC_ADDR : waddr;
  endfunction

endpackage

// File: rtl/wb_fwd_mux.sv
// Operand bypass for one decode read port.
//   wr_en_i    : a register write is in flight this cycle
//   wr_addr_i  : effective write address
//   wr_data_i  : effective write data
//   raddr_i    : decode read address
//   reg_data_i : register file read data
//   fwd_data_o : wr_data_i on an address match, else reg_data_i
module wb_fwd_mux
  import wb_pkg::*;
#(
  parameter int FW = W,
  parameter int FD = D
) (
  input  logic          wr_en_i,
  input  logic [FD-1:0] wr_addr_i,
  input  logic [FW-1:0] wr_data_i,
  input  logic [FD-1:0] raddr_i,
  input  logic [FW-1:0] reg_data_i,
  output logic [FW-1:0] fwd_data_o
);

  // The accumulator is an ordinary register here, so address 0 forwards too.
  assign fwd_data_o = (wr_en_i && (wr_addr_i == raddr_i)) ? wr_data_i : reg_data_i;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers each retiring instruction (S1), drives the
// register file write port, bypasses the in-flight write to decode reads and
// flags load-use hazards.
//   Clk, Reset                 : clock, async active-low reset
//   ExValid..ExIsLoad, Flush   : retiring instruction from execute
//   MemRdata                   : data-memory read data, valid the cycle after capture
//   DecValid, RaddrA/B         : decode operand reads
//   RegDataA/B                 : register file read data
//   WriteEn..DataIn            : register file write port
//   FwdDataA/B                 : bypassed operands
//   Stall                      : one-cycle load-use stall (combinational)
//   RetireCount                : wrapping count of register writes
module wb_stage
  import wb_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ExValid,
  input  logic         ExWriteEn,
  input  logic         ExImmediate,
  input  logic [W-1:0] ExImmValue,
  input  logic [D-1:0] ExWaddr,
  input  logic [W-1:0] ExAluResult,
  input  logic         ExIsLoad,
  input  logic [W-1:0] MemRdata,
  input  logic         Flush,
  input  logic         DecValid,
  input  logic [D-1:0] RaddrA,
  input  logic [D-1:0] RaddrB,
  input  logic [W-1:0] RegDataA,
  input  logic [W-1:0] RegDataB,
  output logic         WriteEn,
  output logic         Immediate,
  output logic [W-1:0] ImmediateValue,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn,
  output logic [W-1:0] FwdDataA,
  output logic [W-1:0] FwdDataB,
  output logic         Stall,
  output logic [15:0]  RetireCount
);

  wb_slot_t    s1_q, s1_d;
  wb_state_t   state_q;
  logic [15:0] retire_q, retire_d;
  logic        capture;
  logic [D-1:0] ex_ea, wb_ea;
  logic [W-1:0] wb_ed;

  // Flush beats ExValid: a flushed instruction enters S1 as a bubble.
  assign capture = ExValid & ~Flush;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    s1_d           = '0;
    s1_d.valid     = capture;
    s1_d.we        = ExWriteEn;
    s1_d.imm       = ExImmediate;
    s1_d.immval    = ExImmValue;
    s1_d.waddr     = ExWaddr;
    s1_d.aluresult = ExAluResult;
    s1_d.isload    = ExIsLoad;
  end

  // The FSM state and S1.valid always move together; both qualify the write.
  assign WriteEn        = s1_q.valid & (state_q == WRITE) & s1_q.we;
  assign Immediate      = s1_q.imm;
  assign ImmediateValue = s1_q.immval;
  assign Waddr          = s1_q.waddr;
  // Load data arrives the cycle after capture and is muxed in directly.
  assign DataIn         = s1_q.isload ? MemRdata : s1_q.aluresult;

  assign wb_ea = eff_addr(s1_q.imm, s1_q.waddr);
  assign wb_ed = s1_q.imm ? s1_q.immval : DataIn;

  wb_fwd_mux u_fwd_a (
    .wr_en_i    (WriteEn),
    .wr_addr_i  (wb_ea),
    .wr_data_i  (wb_ed),
    .raddr_i    (RaddrA),
    .reg_data_i (RegDataA),
    .fwd_data_o (FwdDataA)
  );

  wb_fwd_mux u_fwd_b (
    .wr_en_i    (WriteEn),
    .wr_addr_i  (wb_ea),
    .wr_data_i  (wb_ed),
    .raddr_i    (RaddrB),
    .reg_data_i (RegDataB),
    .fwd_data_o (FwdDataB)
  );

  // A load's data is not available until after capture, so a decode read of
  // its target must wait one cycle. Upstream inserts the bubble.
  assign ex_ea = eff_addr(ExImmediate, ExWaddr);
  assign Stall = DecValid & ExValid & ExIsLoad & ExWriteEn & ~Flush &
                 ((ex_ea == RaddrA) | (ex_ea == RaddrB));

  assign retire_d    = WriteEn ? retire_q + 16'd1 : retire_q;
  assign RetireCount = retire_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  // NOTE: all state is cleared by reset; a write pending in S1 is dropped.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q     <= '0;
      retire_q <= '0;
    end else begin
      s1_q     <= s1_d;
      retire_q <= retire_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (capture)  state_q <= WRITE;
        WRITE:   if (!capture) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ExValid, ExWriteEn, ExImmediate, ExIsLoad, Flush, DecValid;
  logic [7:0]  ExImmValue, ExAluResult, MemRdata, RegDataA, RegDataB;
  logic [3:0]  ExWaddr, RaddrA, RaddrB;
  logic        WriteEn, Immediate, Stall;
  logic [7:0]  ImmediateValue, DataIn, FwdDataA, FwdDataB;
  logic [3:0]  Waddr;
  logic [15:0] RetireCount;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  wb_stage dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ExValid        (ExValid),
    .ExWriteEn      (ExWriteEn),
    .ExImmediate    (ExImmediate),
    .ExImmValue     (ExImmValue),
    .ExWaddr        (ExWaddr),
    .ExAluResult    (ExAluResult),
    .ExIsLoad       (ExIsLoad),
    .MemRdata       (MemRdata),
    .Flush          (Flush),
    .DecValid       (DecValid),
    .RaddrA         (RaddrA),
    .RaddrB         (RaddrB),
    .RegDataA       (RegDataA),
    .RegDataB       (RegDataB),
    .WriteEn        (WriteEn),
    .Immediate      (Immediate),
    .ImmediateValue (ImmediateValue),
    .Waddr          (Waddr),
    .DataIn         (DataIn),
    .FwdDataA       (FwdDataA),
    .FwdDataB       (FwdDataB),
    .Stall          (Stall),
    .RetireCount    (RetireCount)
  );

  // One cycle: inputs driven for the cycle, and the outputs expected during
  // that cycle (S1 from the previous row plus these inputs).
  typedef struct {
    logic        ev, we, imm;
    logic [7:0]  immv;
    logic [3:0]  wa;
    logic [7:0]  alu;
    logic        ld;
    logic [7:0]  mrd;
    logic        fl, dv;
    logic [3:0]  ra, rb;
    logic [7:0]  rda, rdb;
    logic        e_we, e_imm;
    logic [7:0]  e_immv;
    logic [3:0]  e_wa;
    logic [7:0]  e_din, e_fa, e_fb;
    logic        e_stall;
    logic [15:0] e_rc;
  } vec_t;

  localparam int NV = 13;
  vec_t vec [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ExValid = 0; ExWriteEn = 0; ExImmediate = 0; ExImmValue = 0; ExWaddr = 0;
    ExAluResult = 0; ExIsLoad = 0; MemRdata = 0; Flush = 0; DecValid = 0;
    RaddrA = 0; RaddrB = 0; RegDataA = 8'h11; RegDataB = 8'h22;
  endtask

  initial begin
    //            ev we im immv  wa alu   ld mrd   fl dv ra rb rda    rdb     we im immv  wa din   fa     fb     st rc
    vec[0]  = '{0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 0, 0, 'h11, 'h22,  0, 0, 0,     0, 0,     'h11, 'h22,  0, 0};
    vec[1]  = '{1, 1, 0, 0,     5, 'h3C,  0, 0,     0, 0, 0, 0, 'h11, 'h22,  0, 0, 0,     0, 0,     'h11, 'h22,  0, 0};
    vec[2]  = '{1, 1, 1, 'h1E,  7, 0,     0, 0,     0, 0, 5, 3, 'h11, 'h22,  1, 0, 0,     5, 'h3C,  'h3C, 'h22,  0, 0};
    vec[3]  = '{1, 1, 0, 0,     2, 'h99,  1, 0,     0, 1, 0, 2, 'h11, 'h22,  1, 1, 'h1E,  7, 0,     'h1E, 'h22,  1, 1};
    vec[4]  = '{0, 0, 0, 0,     0, 0,     0, 'hA5,  0, 1, 1, 2, 'h11, 'h22,  1, 0, 0,     2, 'hA5,  'h11, 'hA5,  0, 2};
    vec[5]  = '{1, 1, 0, 0,     3, 'h77,  1, 0,     1, 1, 3, 3, 'h11, 'h22,  0, 0, 0,     0, 0,     'h11, 'h22,  0, 3};
    vec[6]  = '{0, 0, 0, 0,     0, 0,     0, 'h5A,  0, 0, 3, 3, 'h11, 'h22,  0, 0, 0,     3, 'h5A,  'h11, 'h22,  0, 3};
    vec[7]  = '{1, 0, 0, 0,     4, 0,     1, 0,     0, 1, 4, 0, 'h11, 'h22,  0, 0, 0,     0, 0,     'h11, 'h22,  0, 3};
    vec[8]  = '{1, 1, 0, 0,     6, 0,     1, 'h33,  0, 1, 6, 0, 'h11, 'h22,  0, 0, 0,     4, 'h33,  'h11, 'h22,  1, 3};
    vec[9]  = '{0, 0, 0, 0,     0, 0,     0, 'h44,  0, 0, 6, 6, 'h11, 'h22,  1, 0, 0,     6, 'h44,  'h44, 'h44,  0, 3};
    vec[10] = '{1, 1, 1, 'h42,  9, 0,     1, 0,     0, 1, 0, 5, 'h11, 'h22,  0, 0, 0,     0, 0,     'h11, 'h22,  1, 4};
    vec[11] = '{0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 0, 9, 'h11, 'h22,  1, 1, 'h42,  9, 0,     'h42, 'h22,  0, 4};
    vec[12] = '{0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 0, 0, 'h11, 'h22,  0, 0, 0,     0, 0,     'h11, 'h22,  0, 5};

    idle_inputs();
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    check("rst.we",   {15'd0, WriteEn},     16'h0);
    check("rst.din",  {8'd0, DataIn},       16'h0);
    check("rst.fa",   {8'd0, FwdDataA},     16'h11);
    check("rst.rc",   RetireCount,          16'h0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      ExValid = vec[i].ev;  ExWriteEn = vec[i].we; ExImmediate = vec[i].imm;
      ExImmValue = vec[i].immv; ExWaddr = vec[i].wa; ExAluResult = vec[i].alu;
      ExIsLoad = vec[i].ld; MemRdata = vec[i].mrd; Flush = vec[i].fl;
      DecValid = vec[i].dv; RaddrA = vec[i].ra; RaddrB = vec[i].rb;
      RegDataA = vec[i].rda; RegDataB = vec[i].rdb;
      #2;
      check($sformatf("v%0d.we", i),    {15'd0, WriteEn},        {15'd0, vec[i].e_we});
      check($sformatf("v%0d.imm", i),   {15'd0, Immediate},      {15'd0, vec[i].e_imm});
      check($sformatf("v%0d.immv", i),  {8'd0, ImmediateValue},  {8'd0, vec[i].e_immv});
      check($sformatf("v%0d.wa", i),    {12'd0, Waddr},          {12'd0, vec[i].e_wa});
      check($sformatf("v%0d.din", i),   {8'd0, DataIn},          {8'd0, vec[i].e_din});
      check($sformatf("v%0d.fa", i),    {8'd0, FwdDataA},        {8'd0, vec[i].e_fa});
      check($sformatf("v%0d.fb", i),    {8'd0, FwdDataB},        {8'd0, vec[i].e_fb});
      check($sformatf("v%0d.stall", i), {15'd0, Stall},          {15'd0, vec[i].e_stall});
      check($sformatf("v%0d.rc", i),    RetireCount,             vec[i].e_rc);
    end

    // Reset mid-write: capture a write to r4, then reset before it commits.
    @(negedge Clk);
    idle_inputs();
    ExValid = 1; ExWriteEn = 1; ExWaddr = 4; ExAluResult = 8'hAB; RaddrA = 4;
    @(negedge Clk);
    idle_inputs();
    RaddrA = 4;
    #2;
    check("mid.we_before",  {15'd0, WriteEn},  16'h1);
    check("mid.fa_before",  {8'd0, FwdDataA},  16'h00AB);
    Reset = 1'b0;
    #1;
    check("mid.we_async",   {15'd0, WriteEn},  16'h0);
    check("mid.wa_async",   {12'd0, Waddr},    16'h0);
    check("mid.din_async",  {8'd0, DataIn},    16'h0);
    check("mid.fa_async",   {8'd0, FwdDataA},  16'h11);
    check("mid.rc_async",   RetireCount,       16'h0);
    @(posedge Clk);
    #1;
    check("mid.we_edge",    {15'd0, WriteEn},  16'h0);
    check("mid.rc_edge",    RetireCount,       16'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid.rc_release", RetireCount,       16'h0);

    // Counter wrap: 65535 writes, then one more.
    ExValid = 1; ExWriteEn = 1; ExWaddr = 1; ExAluResult = 8'h01;
    repeat (65535) @(posedge Clk);
    @(negedge Clk);
    ExValid = 0;
    @(posedge Clk);
    @(negedge Clk);
    check("wrap.rc_ffff",   RetireCount,       16'hFFFF);
    check("wrap.we_idle",   {15'd0, WriteEn},  16'h0);
    ExValid = 1;
    @(negedge Clk);
    ExValid = 0;
    check("wrap.we_last",   {15'd0, WriteEn},  16'h1);
    @(negedge Clk);
    check("wrap.rc_0000",   RetireCount,       16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
